// File: rtl/leaf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : leaf_pkg
//  Purpose  : Shared widths, packet field offsets and packet type for the
//             leaf outbound arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package leaf_pkg;

  localparam int PAYLOAD_BITS          = 32;
  localparam int NUM_LEAF_BITS         = 5;
  localparam int NUM_PORT_BITS         = 4;
  localparam int NUM_ADDR_BITS         = 7;
  localparam int PACKET_BITS           = 1 + NUM_LEAF_BITS + NUM_PORT_BITS
                                         + NUM_ADDR_BITS + PAYLOAD_BITS;
  localparam int NUM_OUT_PORTS         = 4;
  localparam int FREESPACE_UPDATE_SIZE = 64;

  // Credit ceiling equals the depth of a receive buffer.
  localparam int CREDIT_MAX  = 1 << NUM_ADDR_BITS;
  localparam int CREDIT_BITS = NUM_ADDR_BITS + 1;
  localparam int PTR_BITS    = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

  // Packet field positions, MSB to LSB.
  localparam int VALID_BIT = 48;
  localparam int LEAF_LSB  = 43;
  localparam int PORT_LSB  = 39;
  localparam int ADDR_LSB  = 32;

  typedef struct packed {
    logic                     valid;
    logic [NUM_LEAF_BITS-1:0] dest_leaf;
    logic [NUM_PORT_BITS-1:0] dest_port;
    logic [NUM_ADDR_BITS-1:0] addr;
    logic [PAYLOAD_BITS-1:0]  payload;
  } packet_t;

  // Assemble a valid outbound packet from its fields.
  function automatic packet_t make_packet(
    input logic [NUM_LEAF_BITS-1:0] leaf,
    input logic [NUM_PORT_BITS-1:0] port,
    input logic [NUM_ADDR_BITS-1:0] addr,
    input logic [PAYLOAD_BITS-1:0]  payload
  );
    logic [PACKET_BITS-1:0] v;
    v                              = '0;
    v[VALID_BIT]                   = 1'b1;
    v[LEAF_LSB +: NUM_LEAF_BITS]   = leaf;
    v[PORT_LSB +: NUM_PORT_BITS]   = port;
    v[ADDR_LSB +: NUM_ADDR_BITS]   = addr;
    v[0 +: PAYLOAD_BITS]           = payload;
    return packet_t'(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin arbiter. Searches upward from the
//             request after last_grant and returns a one-hot grant.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import leaf_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int RR_PTR_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]     req,
  input  logic [RR_PTR_BITS-1:0] last_grant,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   any_grant
);

  // First requester found after last_grant, wrapping modulo NUM_REQ.
  always_comb begin
    int                     w_sum;
    logic [RR_PTR_BITS-1:0] w_idx;
    grant     = '0;
    any_grant = 1'b0;
    w_sum     = 0;
    w_idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = int'(last_grant) + k;
      if (w_sum >= NUM_REQ) begin
        w_sum = w_sum - NUM_REQ;
      end
      w_idx = RR_PTR_BITS'(w_sum);
      if (!any_grant && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        any_grant    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/leaf_out_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : leaf_out_arbiter
//  Purpose  : Shares one leaf's outbound packet channel among its user output
//             streams with round-robin arbitration, per-port destination
//             table, receive-address counters and credit-based flow control.
//  Revision : 1.0 - initial release
// ============================================================================
module leaf_out_arbiter
  import leaf_pkg::*;
(
  input  logic                                  clk_user,
  input  logic                                  reset_n,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user2arb,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2arb,
  output logic [NUM_OUT_PORTS-1:0]              ack_arb2user,
  output logic [PACKET_BITS-1:0]                pkt_out,
  output logic                                  pkt_vld,
  input  logic                                  pkt_rdy,
  input  logic                                  cfg_we,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dest_port,
  input  logic                                  credit_upd_vld,
  input  logic [NUM_PORT_BITS-1:0]              credit_upd_port,
  output logic                                  credit_err
);

  // Wide enough to hold credit + update before saturation.
  localparam int SUM_BITS = CREDIT_BITS + 1;

  // Per-port table and counters
  logic [NUM_OUT_PORTS-1:0] r_cfg_valid;
  logic [NUM_LEAF_BITS-1:0] r_dest_leaf [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] r_dest_port [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] r_addr      [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   r_credit    [NUM_OUT_PORTS];

  // Output channel state
  logic [PTR_BITS-1:0]      r_rr_ptr;
  logic [PACKET_BITS-1:0]   r_pkt;
  logic                     r_pkt_vld;
  logic                     r_credit_err;

  logic [NUM_OUT_PORTS-1:0] w_eligible;
  logic [NUM_OUT_PORTS-1:0] w_grant;
  logic                     w_any_grant;
  logic                     w_slot_free;
  logic                     w_send;
  logic [PTR_BITS-1:0]      w_gidx;
  packet_t                  w_pkt;

  logic [NUM_OUT_PORTS-1:0] w_cfg_hit;
  logic [NUM_OUT_PORTS-1:0] w_upd_hit;
  logic [NUM_OUT_PORTS-1:0] w_port_sent;
  logic [NUM_OUT_PORTS-1:0] w_ovf;
  logic [NUM_ADDR_BITS-1:0] w_addr_nxt   [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   w_credit_nxt [NUM_OUT_PORTS];

  // A port may compete only if it is configured and has a free buffer slot.
  for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_elig
    assign w_eligible[i] = vld_user2arb[i] & r_cfg_valid[i] & (r_credit[i] != '0);
  end

  assign w_slot_free = ~r_pkt_vld | pkt_rdy;
  assign w_send      = w_any_grant & w_slot_free;

  rr_arbiter #(
    .NUM_REQ    (NUM_OUT_PORTS)
  ) u_rr_arbiter (
    .req        (w_eligible),
    .last_grant (r_rr_ptr),
    .grant      (w_grant),
    .any_grant  (w_any_grant)
  );

  assign ack_arb2user = w_slot_free ? w_grant : '0;
  assign pkt_out      = r_pkt;
  assign pkt_vld      = r_pkt_vld;
  assign credit_err   = r_credit_err;

  // Select the granted port's index and build its packet from the current table.
  always_comb begin
    w_gidx = '0;
    w_pkt  = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (w_grant[i]) begin
        w_gidx = PTR_BITS'(i);
        w_pkt  = make_packet(r_dest_leaf[i], r_dest_port[i], r_addr[i],
                             din_user2arb[i*PAYLOAD_BITS +: PAYLOAD_BITS]);
      end
    end
  end

  // Next address/credit per port; a send and an update combine before saturating.
  always_comb begin
    logic [SUM_BITS-1:0] w_sum;
    w_sum       = '0;
    w_cfg_hit   = '0;
    w_upd_hit   = '0;
    w_port_sent = '0;
    w_ovf       = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      w_cfg_hit[i]   = cfg_we && (cfg_port == NUM_PORT_BITS'(i));
      w_upd_hit[i]   = credit_upd_vld && (credit_upd_port == NUM_PORT_BITS'(i));
      w_port_sent[i] = w_send & w_grant[i];
      w_addr_nxt[i]  = r_addr[i] + NUM_ADDR_BITS'(w_port_sent[i]);
      w_sum = SUM_BITS'(r_credit[i]) - SUM_BITS'(w_port_sent[i])
            + (w_upd_hit[i] ? SUM_BITS'(FREESPACE_UPDATE_SIZE) : '0);
      if (w_sum > SUM_BITS'(CREDIT_MAX)) begin
        w_credit_nxt[i] = CREDIT_BITS'(CREDIT_MAX);
        w_ovf[i]        = ~w_cfg_hit[i];
      end else begin
        w_credit_nxt[i] = CREDIT_BITS'(w_sum);
      end
    end
  end

  // Output packet register and round-robin pointer.
  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      r_pkt     <= '0;
      r_pkt_vld <= 1'b0;
      r_rr_ptr  <= PTR_BITS'(NUM_OUT_PORTS - 1);
    end else if (w_send) begin
      r_pkt     <= w_pkt;
      r_pkt_vld <= 1'b1;
      r_rr_ptr  <= w_gidx;
    end else if (pkt_rdy) begin
      r_pkt     <= '0;
      r_pkt_vld <= 1'b0;
    end
  end

  // Destination table and counters; a table write overrides the send/update result.
  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      r_cfg_valid  <= '0;
      r_credit_err <= 1'b0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        r_dest_leaf[i] <= '0;
        r_dest_port[i] <= '0;
        r_addr[i]      <= '0;
        r_credit[i]    <= CREDIT_BITS'(CREDIT_MAX);
      end
    end else begin
      if (|w_ovf) begin
        r_credit_err <= 1'b1;
      end
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (w_cfg_hit[i]) begin
          r_cfg_valid[i] <= 1'b1;
          r_dest_leaf[i] <= cfg_dest_leaf;
          r_dest_port[i] <= cfg_dest_port;
          r_addr[i]      <= '0;
          r_credit[i]    <= CREDIT_BITS'(CREDIT_MAX);
        end else begin
          r_addr[i]      <= w_addr_nxt[i];
          r_credit[i]    <= w_credit_nxt[i];
        end
      end
    end
  end

endmodule
`default_nettype wire
